// File: rtl/hex_disp_scan.sv
// Four-digit multiplexed seven-segment driver for active-low common-anode displays.
// Each frame is latched into shadow registers, so the shown digits never tear mid-scan.
module hex_disp_scan #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ce,
  input  logic        en,
  input  logic [15:0] dat,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frm
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_reg, cnt_next;
  logic [1:0]  idx_reg, idx_next;
  logic [15:0] sdat_reg;
  logic [3:0]  sdp_reg;
  logic        frm_reg;
  logic        adv;
  logic        tick;
  logic        load;
  logic [3:0]  lead_zero;
  logic [3:0]  digit;
  logic [6:0]  seg_code;
  logic        blank_hit;

  // The prescaler only moves when both the clock enable and the display enable are high.
  always_comb begin
    adv      = ce & en;
    tick     = adv && (cnt_reg == LAST);
    load     = tick && (idx_reg == 2'd3);
    cnt_next = cnt_reg;
    if (adv)
      cnt_next = tick ? 16'd0 : cnt_reg + 16'd1;
    idx_next = tick ? idx_reg + 2'd1 : idx_reg;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg  <= '0;
      idx_reg  <= '0;
      sdat_reg <= '0;
      sdp_reg  <= '0;
      frm_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      frm_reg <= load;
      if (load) begin
        sdat_reg <= dat;
        sdp_reg  <= dp;
      end
    end
  end

  // lead_zero[k]: shadow digits k..3 are all zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lead
      assign lead_zero[gi] = (sdat_reg[15:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    digit = sdat_reg[4*idx_reg +: 4];
    case (digit)
      4'h0:    seg_code = 7'b1000000;
      4'h1:    seg_code = 7'b1111001;
      4'h2:    seg_code = 7'b0100100;
      4'h3:    seg_code = 7'b0110000;
      4'h4:    seg_code = 7'b0011001;
      4'h5:    seg_code = 7'b0010010;
      4'h6:    seg_code = 7'b0000010;
      4'h7:    seg_code = 7'b1111000;
      4'h8:    seg_code = 7'b0000000;
      4'h9:    seg_code = 7'b0010000;
      4'hA:    seg_code = 7'b0001000;
      4'hB:    seg_code = 7'b0000011;
      4'hC:    seg_code = 7'b1000110;
      4'hD:    seg_code = 7'b0100001;
      4'hE:    seg_code = 7'b0000110;
      default: seg_code = 7'b0001110;
    endcase
  end

  // Digit 0 is never blanked so an all-zero value still shows a single 0.
  always_comb begin
    blank_hit = blank_lz && (idx_reg != 2'd0) && lead_zero[idx_reg];
    AN  = 4'b1111;
    SEG = 7'b1111111;
    DP  = 1'b1;
    if (en && !blank_hit) begin
      AN  = ~(4'b0001 << idx_reg);
      SEG = seg_code;
      DP  = ~sdp_reg[idx_reg];
    end
  end

  assign frm = frm_reg & en;

endmodule
